// File: rtl/io_bus_reg_slave.sv
// Register-bank slave for the 32-bit IO bus: address-window decode, synchronised
// four-phase handshake, NUM_RW read/write registers and NUM_RO read-only status words.
module io_bus_reg_slave #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned NUM_RW      = 8,
    parameter int unsigned NUM_RO      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            handshake1_1,
    output logic                            handshake1_2,
    input  logic [ADDR_WIDTH-1:0]           reg_address,
    input  logic                            RW,
    input  logic [DATA_WIDTH-1:0]           data_out,
    output logic [DATA_WIDTH-1:0]           data_in,
    output logic                            bus_drive,
    output logic [NUM_RW*DATA_WIDTH-1:0]    reg_q,
    input  logic [NUM_RO*DATA_WIDTH-1:0]    status_d,
    output logic [NUM_RW-1:0]               wr_strobe,
    output logic [NUM_RW+NUM_RO-1:0]        rd_strobe,
    output logic                            err
);

    localparam int unsigned TOTAL_N = NUM_RW + NUM_RO;
    localparam int unsigned OFF_W   = (TOTAL_N > 1) ? $clog2(TOTAL_N) : 1;
    localparam logic [31:0] BASE_U  = 32'(BASE_ADDR);
    localparam logic [31:0] TOTAL_U = 32'(TOTAL_N);
    localparam logic [OFF_W:0] NUM_RW_X = (OFF_W + 1)'(NUM_RW);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        ACCESS   = 2'd2,
        ACK      = 2'd3
    } state_e;

    state_e                         state_q, state_d;
    logic [SYNC_STAGES-1:0]         sync_q;
    logic                           h_sync_s;
    logic [31:0]                    addr_ext_s;
    logic [31:0]                    offset_full_s;
    logic                           hit_s;
    logic                           latch_en_s;
    logic                           do_access_s;
    logic [OFF_W-1:0]               off_q;
    logic [OFF_W:0]                 off_ext_s;
    logic                           rw_q;
    logic [DATA_WIDTH-1:0]          wdata_q;
    logic [NUM_RW*DATA_WIDTH-1:0]   regs_q;
    logic [TOTAL_N*DATA_WIDTH-1:0]  all_regs_s;
    logic [DATA_WIDTH-1:0]          rd_data_s;
    logic [DATA_WIDTH-1:0]          data_in_q;
    logic [NUM_RW-1:0]              wr_strobe_q;
    logic [TOTAL_N-1:0]             rd_strobe_q;
    logic                           err_q;
    logic                           ack_q;
    logic                           bus_q;

    // Request synchroniser; preset high so a request held across reset is not seen as new.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], handshake1_1};
        end
    end

    assign h_sync_s = sync_q[SYNC_STAGES-1];

    // Window decode of the live bus address.
    always_comb begin
        addr_ext_s    = 32'(reg_address);
        offset_full_s = addr_ext_s - BASE_U;
        hit_s         = (TOTAL_U != 32'd0) && (addr_ext_s >= BASE_U) && (offset_full_s < TOTAL_U);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and per-state control pulses.
    always_comb begin
        state_d     = state_q;
        latch_en_s  = 1'b0;
        do_access_s = 1'b0;
        case (state_q)
            WAIT_LOW: begin
                if (!h_sync_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_LOW;
                end
            end
            IDLE: begin
                if (h_sync_s && hit_s) begin
                    state_d    = ACCESS;
                    latch_en_s = 1'b1;
                end else if (h_sync_s) begin
                    state_d = WAIT_LOW;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                do_access_s = 1'b1;
                state_d     = ACK;
            end
            ACK: begin
                if (!h_sync_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACK;
                end
            end
            default: begin
                state_d = WAIT_LOW;
            end
        endcase
    end

    // Read mux over RW registers followed by the live status words.
    always_comb begin
        off_ext_s  = {1'b0, off_q};
        all_regs_s = {status_d, regs_q};
        rd_data_s  = all_regs_s[32'(off_q) * DATA_WIDTH +: DATA_WIDTH];
    end

    // Latched request, register bank, read data, strobes and handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            off_q       <= '0;
            rw_q        <= 1'b0;
            wdata_q     <= '0;
            regs_q      <= {NUM_RW{RESET_VAL}};
            data_in_q   <= '0;
            wr_strobe_q <= '0;
            rd_strobe_q <= '0;
            err_q       <= 1'b0;
            ack_q       <= 1'b0;
            bus_q       <= 1'b0;
        end else begin
            // Ack drops on the same edge the FSM leaves ACK after the request falls.
            ack_q       <= (state_q == ACK) && h_sync_s;
            bus_q       <= (state_d == ACCESS) || (state_d == ACK);
            wr_strobe_q <= '0;
            rd_strobe_q <= '0;
            if (latch_en_s) begin
                off_q   <= offset_full_s[OFF_W-1:0];
                rw_q    <= RW;
                wdata_q <= data_out;
            end
            if (do_access_s) begin
                if (rw_q) begin
                    data_in_q   <= rd_data_s;
                    rd_strobe_q <= TOTAL_N'(1'b1) << off_q;
                end else if (off_ext_s < NUM_RW_X) begin
                    regs_q[32'(off_q) * DATA_WIDTH +: DATA_WIDTH] <= wdata_q;
                    wr_strobe_q <= NUM_RW'(1'b1) << off_q;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign handshake1_2 = ack_q;
    assign bus_drive    = bus_q;
    assign data_in      = data_in_q;
    assign reg_q        = regs_q;
    assign wr_strobe    = wr_strobe_q;
    assign rd_strobe    = rd_strobe_q;
    assign err          = err_q;

endmodule

// File: tb/tb_io_bus_reg_slave.sv
// Self-checking bench for io_bus_reg_slave: directed scenarios plus a randomised
// back-to-back run checked against an array model of the register bank.
module tb_io_bus_reg_slave;

    localparam int S = 2;
    localparam int NRW = 8;
    localparam int NRO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          hs = 1'b0;
    logic          ack;
    logic [7:0]    addr = 8'h00;
    logic          rw = 1'b0;
    logic [31:0]   dout = 32'h0;
    logic [31:0]   din;
    logic          bus;
    logic [255:0]  regq;
    logic [127:0]  status_d = 128'h0;
    logic [7:0]    wr_strobe;
    logic [11:0]   rd_strobe;
    logic          err;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_regs [NRW];
    logic [31:0] m_status [NRO];
    logic        m_err;

    io_bus_reg_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .BASE_ADDR(32'h10), .NUM_RW(8),
        .NUM_RO(4), .SYNC_STAGES(2), .RESET_VAL(32'h0)
    ) dut (
        .clk(clk), .reset(reset), .handshake1_1(hs), .handshake1_2(ack),
        .reg_address(addr), .RW(rw), .data_out(dout), .data_in(din),
        .bus_drive(bus), .reg_q(regq), .status_d(status_d),
        .wr_strobe(wr_strobe), .rd_strobe(rd_strobe), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] model_regq();
        logic [255:0] v;
        for (int i = 0; i < NRW; i++) v[i*32 +: 32] = m_regs[i];
        return v;
    endfunction

    task automatic set_status(input int idx, input logic [31:0] val);
        m_status[idx] = val;
        status_d[idx*32 +: 32] = val;
    endtask

    // Drives one full handshake and reports what was observed; no comparisons here.
    task automatic run_txn(input logic [7:0] a, input logic r, input logic [31:0] d,
                           output int ack_cyc, output int rel_cyc,
                           output logic [7:0] wmask, output int wcnt,
                           output logic [11:0] rmask, output int rcnt,
                           output logic [31:0] early, output bit bus_seen);
        ack_cyc = -1; rel_cyc = -1; wmask = 8'h0; wcnt = 0;
        rmask = 12'h0; rcnt = 0; early = 32'h0; bus_seen = 1'b0;
        addr = a; rw = r; dout = d; hs = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (wr_strobe != 8'h0) begin wcnt++; wmask |= wr_strobe; end
            if (rd_strobe != 12'h0) begin rcnt++; rmask |= rd_strobe; end
            bus_seen |= bus;
            if (n == S + 1) early = din;
            if (n == S) begin addr = 8'($urandom); rw = ~r; dout = $urandom; end
            if (ack) begin ack_cyc = n; break; end
        end
        hs = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (wr_strobe != 8'h0) begin wcnt++; wmask |= wr_strobe; end
            if (rd_strobe != 12'h0) begin rcnt++; rmask |= rd_strobe; end
            bus_seen |= bus;
            if (!ack) begin rel_cyc = n; break; end
        end
        if (ack_cyc < 0) begin
            repeat (4) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; hs = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
        checks++; if (bus !== 1'b0) begin failures++; $display("FAIL reset_bus got=%b exp=0", bus); end
        checks++; if (din !== 32'h0) begin failures++; $display("FAIL reset_din got=%h exp=0", din); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (regq !== 256'h0) begin failures++; $display("FAIL reset_regq got=%h exp=0", regq); end
        checks++; if ({wr_strobe, rd_strobe} !== 20'h0) begin failures++; $display("FAIL reset_strobes got=%h exp=0", {wr_strobe, rd_strobe}); end
        reset = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_write_read();
        int ac, rc, wc, rdc; logic [7:0] wm; logic [11:0] rm; logic [31:0] e; bit bs;
        run_txn(8'h13, 1'b0, 32'hDEADBEEF, ac, rc, wm, wc, rm, rdc, e, bs);
        m_regs[3] = 32'hDEADBEEF;
        checks++; if (ac !== S + 2) begin failures++; $display("FAIL wr_ack_latency got=%0d exp=%0d", ac, S + 2); end
        checks++; if (rc !== S) begin failures++; $display("FAIL wr_release_latency got=%0d exp=%0d", rc, S); end
        checks++; if (wm !== 8'h08 || wc !== 1 || rdc !== 0) begin failures++; $display("FAIL wr_strobe got=%h/%0d rd=%0d exp=08/1 rd=0", wm, wc, rdc); end
        checks++; if (regq[3*32 +: 32] !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_regq3 got=%h exp=deadbeef", regq[3*32 +: 32]); end
        checks++; if (!bs) begin failures++; $display("FAIL wr_bus_drive got=0 exp=1"); end
        run_txn(8'h13, 1'b1, 32'h0, ac, rc, wm, wc, rm, rdc, e, bs);
        checks++; if (ac !== S + 2) begin failures++; $display("FAIL rd_ack_latency got=%0d exp=%0d", ac, S + 2); end
        checks++; if (e !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data_early got=%h exp=deadbeef", e); end
        checks++; if (din !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data_hold got=%h exp=deadbeef", din); end
        checks++; if (rm !== 12'h008 || rdc !== 1 || wc !== 0) begin failures++; $display("FAIL rd_strobe got=%h/%0d wr=%0d exp=008/1 wr=0", rm, rdc, wc); end
        checks++; if (regq !== model_regq()) begin failures++; $display("FAIL rd_regq_unchanged got=%h exp=%h", regq, model_regq()); end
    endtask

    task automatic test_ro_read();
        int ac, rc, wc, rdc; logic [7:0] wm; logic [11:0] rm; logic [31:0] e; bit bs;
        set_status(1, 32'h12345678);
        run_txn(8'h19, 1'b1, 32'h0, ac, rc, wm, wc, rm, rdc, e, bs);
        checks++; if (din !== 32'h12345678) begin failures++; $display("FAIL ro_read_data got=%h exp=12345678", din); end
        checks++; if (rm !== 12'h200 || rdc !== 1) begin failures++; $display("FAIL ro_read_strobe got=%h/%0d exp=200/1", rm, rdc); end
        checks++; if (ac !== S + 2) begin failures++; $display("FAIL ro_read_ack got=%0d exp=%0d", ac, S + 2); end
    endtask

    task automatic test_ro_write();
        int ac, rc, wc, rdc; logic [7:0] wm; logic [11:0] rm; logic [31:0] e; bit bs;
        run_txn(8'h18, 1'b0, 32'hFFFFFFFF, ac, rc, wm, wc, rm, rdc, e, bs);
        m_err = 1'b1;
        checks++; if (ac !== S + 2 || rc !== S) begin failures++; $display("FAIL ro_write_ack got=%0d/%0d exp=%0d/%0d", ac, rc, S + 2, S); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL ro_write_err got=%b exp=1", err); end
        checks++; if (wc !== 0 || rdc !== 0) begin failures++; $display("FAIL ro_write_strobes got=%0d/%0d exp=0/0", wc, rdc); end
        checks++; if (regq !== model_regq()) begin failures++; $display("FAIL ro_write_regq got=%h exp=%h", regq, model_regq()); end
        run_txn(8'h11, 1'b1, 32'h0, ac, rc, wm, wc, rm, rdc, e, bs);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err); end
    endtask

    task automatic test_miss();
        int ac, rc, wc, rdc; logic [7:0] wm; logic [11:0] rm; logic [31:0] e; bit bs;
        logic [7:0] miss_addr [2];
        miss_addr[0] = 8'h05; miss_addr[1] = 8'h1C;
        for (int k = 0; k < 2; k++) begin
            run_txn(miss_addr[k], k[0], 32'hA5A5A5A5, ac, rc, wm, wc, rm, rdc, e, bs);
            checks++; if (ac !== -1) begin failures++; $display("FAIL miss_ack addr=%h got=%0d exp=-1", miss_addr[k], ac); end
            checks++; if (bs !== 1'b0) begin failures++; $display("FAIL miss_bus addr=%h got=%b exp=0", miss_addr[k], bs); end
            checks++; if (wc !== 0 || rdc !== 0) begin failures++; $display("FAIL miss_strobes addr=%h got=%0d/%0d exp=0/0", miss_addr[k], wc, rdc); end
        end
        checks++; if (regq !== model_regq()) begin failures++; $display("FAIL miss_regq got=%h exp=%h", regq, model_regq()); end
    endtask

    task automatic test_reset_mid_access();
        int ac, rc, wc, rdc, seen, bad; logic [7:0] wm; logic [11:0] rm; logic [31:0] e; bit bs;
        addr = 8'h12; rw = 1'b0; dout = 32'h55AA55AA; hs = 1'b1;
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (ack) begin seen = 1; break; end
        end
        checks++; if (seen !== 1) begin failures++; $display("FAIL mid_reach_ack got=%0d exp=1", seen); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < NRW; i++) m_regs[i] = 32'h0;
        m_err = 1'b0;
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL mid_ack_drop got=%b exp=0", ack); end
        checks++; if (regq !== model_regq()) begin failures++; $display("FAIL mid_regq got=%h exp=%h", regq, model_regq()); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL mid_err got=%b exp=0", err); end
        bad = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (ack || bus || wr_strobe != 8'h0 || rd_strobe != 12'h0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL mid_held_request got=%0d active cycles exp=0", bad); end
        hs = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        run_txn(8'h12, 1'b1, 32'h0, ac, rc, wm, wc, rm, rdc, e, bs);
        checks++; if (ac !== S + 2 || din !== 32'h0) begin failures++; $display("FAIL mid_recover got=%0d/%h exp=%0d/0", ac, din, S + 2); end
    endtask

    task automatic test_back_to_back();
        int ac, rc, wc, rdc; logic [7:0] wm; logic [11:0] rm; logic [31:0] e; bit bs;
        logic [7:0] a; logic r; logic [31:0] d; int off;
        logic [7:0] exp_wm; logic [11:0] exp_rm; int exp_wc, exp_rc; logic [31:0] exp_d;
        for (int k = 0; k < NRO; k++) set_status(k, $urandom);
        for (int t = 0; t < 16; t++) begin
            off = int'($urandom_range(0, NRW + NRO - 1));
            a = 8'(32'h10 + off);
            r = 1'($urandom_range(0, 1));
            d = $urandom;
            exp_wm = 8'h0; exp_rm = 12'h0; exp_wc = 0; exp_rc = 0; exp_d = din;
            if (r) begin
                exp_rm[off] = 1'b1; exp_rc = 1;
                exp_d = (off < NRW) ? m_regs[off] : m_status[off - NRW];
            end else if (off < NRW) begin
                exp_wm[off] = 1'b1; exp_wc = 1;
                m_regs[off] = d;
            end else begin
                m_err = 1'b1;
            end
            run_txn(a, r, d, ac, rc, wm, wc, rm, rdc, e, bs);
            checks++; if (ac !== S + 2 || rc !== S) begin failures++; $display("FAIL b2b_latency t=%0d got=%0d/%0d exp=%0d/%0d", t, ac, rc, S + 2, S); end
            checks++; if (wm !== exp_wm || wc !== exp_wc || rm !== exp_rm || rdc !== exp_rc) begin failures++; $display("FAIL b2b_strobes t=%0d got=%h/%0d %h/%0d exp=%h/%0d %h/%0d", t, wm, wc, rm, rdc, exp_wm, exp_wc, exp_rm, exp_rc); end
            checks++; if (din !== exp_d) begin failures++; $display("FAIL b2b_data t=%0d got=%h exp=%h", t, din, exp_d); end
            checks++; if (regq !== model_regq() || err !== m_err) begin failures++; $display("FAIL b2b_state t=%0d regq=%h err=%b exp regq=%h err=%b", t, regq, err, model_regq(), m_err); end
        end
    endtask

    initial begin
        for (int i = 0; i < NRW; i++) m_regs[i] = 32'h0;
        for (int i = 0; i < NRO; i++) m_status[i] = 32'h0;
        m_err = 1'b0;
        test_reset();
        test_write_read();
        test_ro_read();
        test_ro_write();
        test_miss();
        test_reset_mid_access();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
